// File: rtl/cobi_pkg.sv
// cobi_pkg: shared COBI constants, reader state encoding and a width helper.
package cobi_pkg;
  localparam int COBI_SPINS_PER_CHIP = 64;
  typedef enum logic [2:0] {IDLE, SAMPLE, SETTLE, SHIFT_LO, SHIFT_HI, DONE} reader_state_t;
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/cobi_scan_phase_timer.sv
// cobi_scan_phase_timer: loadable down-counter whose terminal count ends the current phase.
module cobi_scan_phase_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         tc
);
  logic [W-1:0] cnt;
  assign tc = (cnt == '0);
  always_ff @(posedge clk)
    if (!rst_n) cnt <= '0;
    else cnt <= load ? value : (tc ? cnt : cnt - W'(1));
endmodule

// File: rtl/cobi_scanout_reader.sv
// cobi_scanout_reader: samples COBI spins, scans all chains out in parallel and offers the
// deserialized spin vector through a valid/ready handshake.
module cobi_scanout_reader
  import cobi_pkg::*;
#(
  parameter int NUM_CHAINS          = 4,
  parameter int NUM_CHIPS_PER_CHAIN = 1,
  parameter int CLK_DIV             = 2,
  parameter int SAMPLE_CYCLES       = 2,
  parameter int SETTLE_CYCLES       = 2
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic                                                   start,
  output logic                                                   busy,
  output logic                                                   sample_clk,
  output logic                                                   scanout_clk,
  output logic                                                   all_row_hi,
  input  logic [NUM_CHAINS-1:0]                                  scanout_dout64,
  output logic [NUM_CHAINS*COBI_SPINS_PER_CHIP*NUM_CHIPS_PER_CHAIN-1:0] spins,
  output logic                                                   valid,
  input  logic                                                   ready
);
  localparam int BITS = COBI_SPINS_PER_CHIP * NUM_CHIPS_PER_CHAIN;
  localparam int BW   = $clog2(BITS + 1);
  localparam int MAXC = (CLK_DIV > SAMPLE_CYCLES)
                        ? ((CLK_DIV > SETTLE_CYCLES) ? CLK_DIV : SETTLE_CYCLES)
                        : ((SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES);
  localparam int TW   = width_of(MAXC);

  reader_state_t state, next;
  logic load, tc, shift_en, last_bit;
  logic [TW-1:0] load_val;
  logic [BW-1:0] bit_cnt;
  logic [NUM_CHAINS*BITS-1:0] flat;

  // One timer serves every timed phase; it is reloaded on each phase change.
  cobi_scan_phase_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .load (load),
    .value(load_val),
    .tc   (tc)
  );

  assign last_bit = (bit_cnt == BW'(BITS - 1));
  assign load     = (state == IDLE) || tc;
  assign shift_en = (state == SHIFT_LO) && tc;
  assign load_val = (next == SETTLE) ? TW'(SETTLE_CYCLES - 1)
                  : (next == SHIFT_LO || next == SHIFT_HI) ? TW'(CLK_DIV - 1)
                  : TW'(SAMPLE_CYCLES - 1);

  always_comb begin
    next = state;
    case (state)
      IDLE:     next = (start && !valid) ? SAMPLE : IDLE;
      SAMPLE:   next = tc ? SETTLE : SAMPLE;
      SETTLE:   next = tc ? SHIFT_LO : SETTLE;
      SHIFT_LO: next = tc ? SHIFT_HI : SHIFT_LO;
      SHIFT_HI: next = tc ? (last_bit ? DONE : SHIFT_LO) : SHIFT_HI;
      DONE:     next = IDLE;
      default:  next = IDLE;
    endcase
  end

  always_ff @(posedge clk)
    if (!rst_n) bit_cnt <= '0;
    else if (state == SETTLE) bit_cnt <= '0;
    else if (state == SHIFT_HI && tc) bit_cnt <= bit_cnt + BW'(1);

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk)
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      sample_clk  <= 1'b0;
      scanout_clk <= 1'b0;
      all_row_hi  <= 1'b0;
      valid       <= 1'b0;
      spins       <= '0;
    end else begin
      state       <= next;
      busy        <= next inside {SAMPLE, SETTLE, SHIFT_LO, SHIFT_HI};
      sample_clk  <= (next == SAMPLE);
      scanout_clk <= (next == SHIFT_HI);
      all_row_hi  <= 1'b0;
      valid       <= (state == DONE) || (valid && !ready);
      if (state == DONE) spins <= flat;
    end

  for (genvar g = 0; g < NUM_CHAINS; g++) begin : g_chain
    logic [BITS-1:0] sr;
    always_ff @(posedge clk)
      if (!rst_n) sr <= '0;
      else if (shift_en) sr <= {sr[BITS-2:0], scanout_dout64[g]};
    assign flat[g*BITS +: BITS] = sr;
  end
endmodule

// File: tb/tb_cobi_scanout_reader.sv
// tb_cobi_scanout_reader: three reader configurations, each driving a behavioural scan-chain model.
module tb_cobi_scanout_reader;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  int checks = 0, errors = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic start_a = 0, ready_a = 1, busy_a, sample_a, scan_a, arh_a, valid_a;
  logic [3:0] dout_a;
  logic [255:0] spins_a;
  logic [3:0][63:0] st_a, ch_a;
  int rises_a = 0, samp_a = 0;

  logic start_b = 0, ready_b = 1, busy_b, sample_b, scan_b, arh_b, valid_b;
  logic [3:0] dout_b;
  logic [511:0] spins_b;
  logic [3:0][127:0] st_b, ch_b;

  logic start_c = 0, ready_c = 1, busy_c, sample_c, scan_c, arh_c, valid_c;
  logic [3:0] dout_c;
  logic [255:0] spins_c;
  logic [3:0][63:0] st_c, ch_c;
  int rises_c = 0;

  cobi_scanout_reader dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .sample_clk(sample_a),
    .scanout_clk(scan_a), .all_row_hi(arh_a), .scanout_dout64(dout_a), .spins(spins_a),
    .valid(valid_a), .ready(ready_a));
  cobi_scanout_reader #(.NUM_CHIPS_PER_CHAIN(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .sample_clk(sample_b),
    .scanout_clk(scan_b), .all_row_hi(arh_b), .scanout_dout64(dout_b), .spins(spins_b),
    .valid(valid_b), .ready(ready_b));
  cobi_scanout_reader #(.CLK_DIV(1), .SAMPLE_CYCLES(1), .SETTLE_CYCLES(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .sample_clk(sample_c),
    .scanout_clk(scan_c), .all_row_hi(arh_c), .scanout_dout64(dout_c), .spins(spins_c),
    .valid(valid_c), .ready(ready_c));

  // Chain model: sample loads the spin state, each scan-clock rise shifts toward DOUT at the MSB.
  always @(posedge sample_a or posedge scan_a)
    if (sample_a) ch_a <= st_a;
    else for (int c = 0; c < 4; c++) ch_a[c] <= {ch_a[c][62:0], arh_a};
  always @(posedge sample_b or posedge scan_b)
    if (sample_b) ch_b <= st_b;
    else for (int c = 0; c < 4; c++) ch_b[c] <= {ch_b[c][126:0], arh_b};
  always @(posedge sample_c or posedge scan_c)
    if (sample_c) ch_c <= st_c;
    else for (int c = 0; c < 4; c++) ch_c[c] <= {ch_c[c][62:0], arh_c};
  always_comb for (int c = 0; c < 4; c++) dout_a[c] = ch_a[c][63];
  always_comb for (int c = 0; c < 4; c++) dout_b[c] = ch_b[c][127];
  always_comb for (int c = 0; c < 4; c++) dout_c[c] = ch_c[c][63];
  always @(posedge scan_a) rises_a <= rises_a + 1;
  always @(posedge sample_a) samp_a <= samp_a + 1;
  always @(posedge scan_c) rises_c <= rises_c + 1;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic vld(input int id);
    return id == 0 ? valid_a : id == 1 ? valid_b : valid_c;
  endfunction
  function automatic logic busy_of(input int id);
    return id == 0 ? busy_a : id == 1 ? busy_b : busy_c;
  endfunction
  function automatic logic scan_of(input int id);
    return id == 0 ? scan_a : id == 1 ? scan_b : scan_c;
  endfunction

  task automatic set_start(input int id, input logic v);
    if (id == 0) start_a = v;
    else if (id == 1) start_b = v;
    else start_c = v;
  endtask

  task automatic readout(input int id, output int lat, output int busy_n, output int hi_n);
    set_start(id, 1'b1);
    busy_n = 0;
    hi_n = 0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    set_start(id, 1'b0);
    while (!vld(id) && lat < 2000) begin
      busy_n += int'(busy_of(id));
      hi_n += int'(scan_of(id));
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int lat, bn, hn, r0, s0, n, t1, t2;
  initial begin
    st_a = {64'hA5A55A5AC3C33C3C, 64'hFEDCBA9876543210, 64'h0123456789ABCDEF, 64'hDEADBEEF01234567};
    st_b = {{64'h3333333333333333, 64'h4444444444444444}, {64'h5555555555555555, 64'h6666666666666666},
            {64'h1111111111111111, 64'h2222222222222222}, {64'hF000000000000000, 64'h000000000000000F}};
    st_c = {64'h0F0F0F0F0F0F0F0F, 64'h8000000000000001, 64'h7FFFFFFFFFFFFFFE, 64'hCAFEF00D12345678};
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {busy_a, sample_a, scan_a, arh_a, valid_a}, 0);
    chk("rst_spins", spins_a, 0);
    rst_n = 1'b1;
    @(negedge clk);

    r0 = rises_a;
    readout(0, lat, bn, hn);
    chk("t1_latency", lat, 262);
    chk("t1_spins", spins_a, st_a);
    chk("t1_rises", rises_a - r0, 64);
    chk("t1_busy_cycles", bn, 260);
    chk("t1_row_hi", arh_a, 0);
    @(negedge clk);
    chk("t1_valid_one", valid_a, 0);

    readout(1, lat, bn, hn);
    chk("t2_latency", lat, 518);
    chk("t2_spins", spins_b, st_b);
    chk("t2_chip1", spins_b[127:64], 64'hF000000000000000);
    chk("t2_chip0", spins_b[63:0], 64'h000000000000000F);
    @(negedge clk);

    ready_a = 1'b0;
    readout(0, lat, bn, hn);
    chk("t3_latency", lat, 262);
    s0 = samp_a;
    repeat (20) begin
      start_a = ~start_a;
      @(negedge clk);
      chk("t3_hold", {valid_a, spins_a}, {1'b1, st_a});
    end
    chk("t3_no_sample", samp_a - s0, 0);
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    chk("t3_valid_drop", valid_a, 0);
    chk("t3_start_not_taken", busy_a, 0);
    readout(0, lat, bn, hn);
    chk("t3_relatency", lat, 262);
    chk("t3_spins", spins_a, st_a);
    @(negedge clk);

    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    r0 = rises_a;
    n = 0;
    while (rises_a - r0 < 31 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("t4_in_shift_hi", {busy_a, scan_a}, 2'b11);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_outs", {busy_a, sample_a, scan_a, arh_a, valid_a}, 0);
    chk("t4_rst_spins", spins_a, 0);
    rst_n = 1'b1;
    @(negedge clk);
    readout(0, lat, bn, hn);
    chk("t4_latency", lat, 262);
    chk("t4_spins", spins_a, st_a);
    @(negedge clk);

    r0 = rises_c;
    readout(2, lat, bn, hn);
    chk("t5_latency", lat, 132);
    chk("t5_spins", spins_c, st_c);
    chk("t5_rises", rises_c - r0, 64);
    chk("t5_hi_cycles", hn, 64);
    chk("t5_busy_cycles", bn, 130);
    @(negedge clk);

    start_a = 1'b1;
    n = 0;
    while (!valid_a && n < 600) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc;
    chk("t6_first_spins", spins_a, st_a);
    @(negedge clk);
    chk("t6_valid_drop", valid_a, 0);
    n = 0;
    while (!valid_a && n < 600) begin
      @(negedge clk);
      n++;
    end
    t2 = cyc;
    start_a = 1'b0;
    chk("t6_period", t2 - t1, 263);
    chk("t6_second_spins", spins_a, st_a);
    repeat (3) @(negedge clk);
    chk("t6_idle_after", {busy_a, valid_a}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
